// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0]  PC_SRC_JALR   = 2'b01;
  localparam logic [1:0]  PC_SRC_TARGET = 2'b10;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

endpackage

// File: rtl/pc_redirect_sel.sv
// Redirect detection and target selection; the only decoder of pc_src.
module pc_redirect_sel
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc_jalr,
  input  logic [XLEN-1:0] pc_target,
  output logic            redirect,
  output logic [XLEN-1:0] target
);

  // Branch target outranks JALR; code 11 alone is not a redirect.
  always_comb begin
    redirect = 1'b0;
    target   = pc_target;
    if (branch_taken) begin
      redirect = 1'b1;
      target   = pc_target;
    end else begin
      case (pc_src)
        PC_SRC_TARGET: begin
          redirect = 1'b1;
          target   = pc_target;
        end
        PC_SRC_JALR: begin
          redirect = 1'b1;
          target   = pc_jalr;
        end
        default: begin
          redirect = 1'b0;
          target   = pc_target;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem read, one output slot.
// Optional misaligned-target fault state under FETCH_MISALIGN_CHK_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc_jalr,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [31:0]     if_instr,
  output logic            if_fault
);

  localparam logic [XLEN-1:0] INC4 = XLEN'(32'd4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            if_fault_q, if_fault_d;

  logic            redirect_s;
  logic [XLEN-1:0] sel_target_s;
  logic [XLEN-1:0] target_s;
  logic            req_fire_s;
  logic            owed_s;

  pc_redirect_sel #(.XLEN(XLEN)) u_redirect_sel (
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .pc_jalr      (pc_jalr),
    .pc_target    (pc_target),
    .redirect     (redirect_s),
    .target       (sel_target_s)
  );

`ifdef FETCH_MISALIGN_CHK_EN
  assign target_s = sel_target_s;
`else
  assign target_s = sel_target_s & ~XLEN'(32'd3);
`endif

  // Requests never depend on pc_src; a pending drop blocks issue until the stale response lands.
  assign imem_req_valid = rst_n && (state_q == REQ) && !drop_q && (!if_valid_q || if_ready);
  assign imem_req_addr  = pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign owed_s         = ((state_q == WAIT) && !imem_rsp_valid) || req_fire_s;

  // Next-state, PC and slot update; redirect overrides stall and capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_instr_d    = if_instr_q;
    if_fault_d    = if_fault_q;
    if (redirect_s) begin
      pc_d       = target_s;
      state_d    = REQ;
      if_valid_d = 1'b0;
      if_fault_d = 1'b0;
      drop_d     = (drop_q && !imem_rsp_valid) || owed_s;
`ifdef FETCH_MISALIGN_CHK_EN
      if (target_s[1:0] != 2'b00) begin
        state_d       = FAULT;
        if_valid_d    = 1'b1;
        if_fault_d    = 1'b1;
        if_pc_d       = target_s;
        if_pc_plus4_d = target_s + INC4;
        if_instr_d    = NOP_INSTR;
      end else begin
        state_d = REQ;
      end
`endif
    end else begin
      if (if_valid_q && if_ready) begin
        if_valid_d = 1'b0;
      end else begin
        if_valid_d = if_valid_q;
      end
      drop_d = drop_q && !imem_rsp_valid;
      case (state_q)
        REQ: begin
          if (req_fire_s) begin
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_d = REQ;
            if (!drop_q) begin
              if_valid_d    = 1'b1;
              if_pc_d       = pc_q;
              if_pc_plus4_d = pc_q + INC4;
              if_instr_d    = imem_rsp_data;
              if_fault_d    = 1'b0;
              pc_d          = pc_q + INC4;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            state_d = WAIT;
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        FAULT: begin
          state_d    = FAULT;
          if_valid_d = 1'b1;
        end
`endif
        default: begin
          state_d = REQ;
        end
      endcase
    end
  end

  // State and output-slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= {XLEN{1'b0}};
      if_pc_plus4_q <= {XLEN{1'b0}};
      if_instr_q    <= 32'h0000_0000;
      if_fault_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_instr_q    <= if_instr_d;
      if_fault_q    <= if_fault_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign if_instr    = if_instr_q;
  assign if_fault    = if_fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed cycle-table bench for pc_fetch_unit with a latency-programmable imem model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] pc_jalr, pc_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_pc_plus4, if_instr;
  logic        if_fault;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  logic        owed;
  int          rem;
  logic [31:0] rsp_addr;

  typedef struct {
    logic [1:0]  s;
    logic        bt;
    logic [31:0] jalr;
    logic [31:0] tgt;
    logic        rdy;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  vec_t tbl [0:28];

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .branch_taken   (branch_taken),
    .pc_jalr        (pc_jalr),
    .pc_target      (pc_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0010_0093;
    else return {a[15:0], 16'h0113};
  endfunction

  function automatic vec_t mk(input logic [1:0] s, input logic bt, input logic [31:0] jalr,
                              input logic [31:0] tgt, input logic rdy, input int lat,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ep4,
                              input logic [31:0] ei, input logic ef);
    vec_t v;
    v.s = s; v.bt = bt; v.jalr = jalr; v.tgt = tgt; v.rdy = rdy; v.lat = lat;
    v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_pc = ep; v.e_pc4 = ep4;
    v.e_instr = ei; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v, input int idx);
    logic        fired;
    logic [31:0] faddr;
    pc_src       = v.s;
    branch_taken = v.bt;
    pc_jalr      = v.jalr;
    pc_target    = v.tgt;
    if_ready     = v.rdy;
    @(negedge clk);
    chk($sformatf("c%0d req_valid", idx), {31'd0, imem_req_valid}, {31'd0, v.e_req});
    if (v.e_req) chk($sformatf("c%0d req_addr", idx), imem_req_addr, v.e_addr);
    chk($sformatf("c%0d if_valid", idx), {31'd0, if_valid}, {31'd0, v.e_val});
    chk($sformatf("c%0d if_pc", idx), if_pc, v.e_pc);
    chk($sformatf("c%0d if_pc_plus4", idx), if_pc_plus4, v.e_pc4);
    chk($sformatf("c%0d if_instr", idx), if_instr, v.e_instr);
    chk($sformatf("c%0d if_fault", idx), {31'd0, if_fault}, {31'd0, v.e_fault});
    fired = imem_req_valid && imem_req_ready;
    faddr = imem_req_addr;
    @(posedge clk);
    #1;
    // response occupies exactly one cycle, lat cycles after acceptance
    if (imem_rsp_valid) begin
      imem_rsp_valid = 1'b0;
      owed = 1'b0;
    end
    if (fired) begin
      owed = 1'b1;
      rem = v.lat;
      rsp_addr = faddr;
    end
    if (owed) begin
      rem--;
      if (rem == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = m(rsp_addr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_src = 2'b00; branch_taken = 1'b0; pc_jalr = 32'h0; pc_target = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; if_ready = 1'b1;
    owed = 1'b0; rem = 0; rsp_addr = 32'h0;

    //            s     bt    jalr          tgt           rdy  lat  req   addr          val   pc            pc4           instr            flt
    tbl[0]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'h0,        1'b0,32'h0,        32'h0,        32'h0,           1'b0);
    tbl[1]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h0,           1'b0);
    tbl[2]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'h4,        1'b1,32'h0,        32'h4,        m(32'h0),        1'b0);
    tbl[3]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h0,        32'h4,        m(32'h0),        1'b0);
    tbl[4]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b0,1, 1'b0,32'h8,        1'b1,32'h4,        32'h8,        m(32'h4),        1'b0);
    tbl[5]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b0,1, 1'b0,32'h8,        1'b1,32'h4,        32'h8,        m(32'h4),        1'b0);
    tbl[6]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'h8,        1'b1,32'h4,        32'h8,        m(32'h4),        1'b0);
    tbl[7]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h4,        32'h8,        m(32'h4),        1'b0);
    tbl[8]  = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,3, 1'b1,32'hC,        1'b1,32'h8,        32'hC,        m(32'h8),        1'b0);
    tbl[9]  = mk(2'b10,1'b0,32'h0,        32'h80,       1'b1,1, 1'b0,32'h0,        1'b0,32'h8,        32'hC,        m(32'h8),        1'b0);
    tbl[10] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h8,        32'hC,        m(32'h8),        1'b0);
    tbl[11] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h8,        32'hC,        m(32'h8),        1'b0);
    tbl[12] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'h80,       1'b0,32'h8,        32'hC,        m(32'h8),        1'b0);
    tbl[13] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h8,        32'hC,        m(32'h8),        1'b0);
    tbl[14] = mk(2'b01,1'b1,32'h40,       32'h100,      1'b1,1, 1'b1,32'h84,       1'b1,32'h80,       32'h84,       m(32'h80),       1'b0);
    tbl[15] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h80,       32'h84,       m(32'h80),       1'b0);
    tbl[16] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'h100,      1'b0,32'h80,       32'h84,       m(32'h80),       1'b0);
    tbl[17] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h80,       32'h84,       m(32'h80),       1'b0);
    tbl[18] = mk(2'b11,1'b0,32'h40,       32'h300,      1'b1,1, 1'b1,32'h104,      1'b1,32'h100,      32'h104,      m(32'h100),      1'b0);
    tbl[19] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h100,      32'h104,      m(32'h100),      1'b0);
    tbl[20] = mk(2'b10,1'b0,32'h0,        32'hFFFF_FFFC,1'b1,1, 1'b1,32'h108,      1'b1,32'h104,      32'h108,      m(32'h104),      1'b0);
    tbl[21] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h104,      32'h108,      m(32'h104),      1'b0);
    tbl[22] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'hFFFF_FFFC,1'b0,32'h104,      32'h108,      m(32'h104),      1'b0);
    tbl[23] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h104,      32'h108,      m(32'h104),      1'b0);
    tbl[24] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'h0,        1'b1,32'hFFFF_FFFC,32'h0,        m(32'hFFFF_FFFC),1'b0);
    tbl[25] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'hFFFF_FFFC,32'h0,        m(32'hFFFF_FFFC),1'b0);
    tbl[26] = mk(2'b01,1'b0,32'h40,       32'h500,      1'b1,1, 1'b1,32'h4,        1'b1,32'h0,        32'h4,        m(32'h0),        1'b0);
    tbl[27] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b0,32'h0,        1'b0,32'h0,        32'h4,        m(32'h0),        1'b0);
    tbl[28] = mk(2'b00,1'b0,32'h0,        32'h0,        1'b1,1, 1'b1,32'h40,       1'b0,32'h0,        32'h4,        m(32'h0),        1'b0);

    // reset state: request must stay low while rst_n is low
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst if_pc_plus4", if_pc_plus4, 32'h0);
    chk("rst if_instr", if_instr, 32'h0);
    chk("rst if_fault", {31'd0, if_fault}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) run_cycle(tbl[i], i);

    // redirect to a misaligned target while the 0x40 response arrives (discarded, nothing owed)
    run_cycle(mk(2'b10,1'b0,32'h0,32'h102,1'b1,1, 1'b0,32'h0,1'b0,32'h0,32'h4,m(32'h0),1'b0), 29);
`ifdef FETCH_MISALIGN_CHK_EN
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b0,32'h0,  1'b1,32'h102,32'h106,32'h0000_0013,1'b1), 30);
    run_cycle(mk(2'b10,1'b0,32'h0,32'h200,1'b1,1, 1'b0,32'h0,  1'b1,32'h102,32'h106,32'h0000_0013,1'b1), 31);
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b1,32'h200,1'b0,32'h102,32'h106,32'h0000_0013,1'b0), 32);
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b0,32'h0,  1'b0,32'h102,32'h106,32'h0000_0013,1'b0), 33);
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b1,32'h204,1'b1,32'h200,32'h204,m(32'h200),1'b0), 34);
`else
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b1,32'h100,1'b0,32'h0,  32'h4,  m(32'h0),  1'b0), 30);
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b0,32'h0,  1'b0,32'h0,  32'h4,  m(32'h0),  1'b0), 31);
    // slot full and stalled, redirect wins: slot invalidated, new target fetched next cycle
    run_cycle(mk(2'b10,1'b0,32'h0,32'h300,1'b0,1, 1'b0,32'h0,  1'b1,32'h100,32'h104,m(32'h100),1'b0), 32);
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b0,1, 1'b1,32'h300,1'b0,32'h100,32'h104,m(32'h100),1'b0), 33);
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b0,32'h0,  1'b0,32'h100,32'h104,m(32'h100),1'b0), 34);
    run_cycle(mk(2'b00,1'b0,32'h0,32'h0,  1'b1,1, 1'b1,32'h304,1'b1,32'h300,32'h304,m(32'h300),1'b0), 35);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
